// File: rtl/csr_trap_ctrl.sv
// Trap/MRET/WFI sequencer between the EX stage and the CSR file.
// Decides machine interrupts, MRET returns and WFI sleep; emits registered strobes and PC redirects.
module csr_trap_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            wfi_i,
    input  logic            mret_i,
    input  logic            stall_i,
    input  logic            irq_ext_i,
    input  logic            irq_tmr_i,
    input  logic            mstatus_mie_i,
    input  logic            mie_meie_i,
    input  logic            mie_mtie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_wait_o,
    output logic            csr_ret_o,
    output logic            trap_take_o,
    output logic [XLEN-1:0] trap_cause_o,
    output logic [XLEN-1:0] trap_epc_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            halt_o
);

    localparam logic [XLEN-1:0] CAUSE_MEI = XLEN'(32'h8000_000B);
    localparam logic [XLEN-1:0] CAUSE_MTI = XLEN'(32'h8000_0007);

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_SLEEP = 3'd1;
    localparam logic [2:0] S_TRAP  = 3'd2;
    localparam logic [2:0] S_RET   = 3'd3;
    localparam logic [2:0] S_WAKE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] wake_pc_q, wake_pc_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            sleep_q, sleep_d;
    logic            trap_q, trap_d;
    logic            ret_q, ret_d;
    logic            redir_q, redir_d;

    logic            pend_ext, pend_tmr, take;
    logic [XLEN-1:0] cause_c;
    logic [XLEN-1:0] tvec_c;

    assign pend_ext = irq_ext_i & mie_meie_i;
    assign pend_tmr = irq_tmr_i & mie_mtie_i;
    assign take     = mstatus_mie_i & (pend_ext | pend_tmr);
    assign cause_c  = pend_ext ? CAUSE_MEI : CAUSE_MTI;
    // Direct mode only: low two mode bits are dropped from the vector.
    assign tvec_c   = mtvec_i & ~XLEN'(3);

    // Next-state and latched trap context.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        wake_pc_d = wake_pc_q;
        case (state_q)
            S_RUN: begin
                if (ex_valid_i && !stall_i) begin
                    if (take) begin
                        state_d = S_TRAP;
                        cause_d = cause_c;
                        epc_d   = ex_pc_i;
                    end else if (mret_i) begin
                        state_d = S_RET;
                    end else if (wfi_i) begin
                        state_d   = S_SLEEP;
                        wake_pc_d = ex_pc_i + XLEN'(4);
                    end
                end
            end
            S_SLEEP: begin
                if (pend_ext || pend_tmr) begin
                    if (take) begin
                        state_d = S_TRAP;
                        cause_d = cause_c;
                        epc_d   = wake_pc_q;
                    end else begin
                        state_d = S_WAKE;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Registered strobes follow the one-cycle event states.
    always_comb begin
        sleep_d    = (state_d == S_SLEEP);
        trap_d     = (state_q == S_TRAP);
        ret_d      = (state_q == S_RET);
        redir_d    = (state_q == S_TRAP) || (state_q == S_RET) || (state_q == S_WAKE);
        redir_pc_d = redir_pc_q;
        case (state_q)
            S_TRAP:  redir_pc_d = tvec_c;
            S_RET:   redir_pc_d = mepc_i;
            S_WAKE:  redir_pc_d = wake_pc_q;
            default: redir_pc_d = redir_pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_RUN;
            cause_q    <= '0;
            epc_q      <= '0;
            wake_pc_q  <= '0;
            redir_pc_q <= '0;
            sleep_q    <= 1'b0;
            trap_q     <= 1'b0;
            ret_q      <= 1'b0;
            redir_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            wake_pc_q  <= wake_pc_d;
            redir_pc_q <= redir_pc_d;
            sleep_q    <= sleep_d;
            trap_q     <= trap_d;
            ret_q      <= ret_d;
            redir_q    <= redir_d;
        end
    end

    assign csr_wait_o    = sleep_q;
    assign halt_o        = sleep_q;
    assign csr_ret_o     = ret_q;
    assign trap_take_o   = trap_q;
    assign trap_cause_o  = cause_q;
    assign trap_epc_o    = epc_q;
    assign redirect_o    = redir_q;
    assign redirect_pc_o = redir_pc_q;
    assign flush_o       = redir_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: a reference model queues expected events,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [31:0] ex_pc_i = '0;
    logic        wfi_i = 1'b0, mret_i = 1'b0, stall_i = 1'b0;
    logic        irq_ext_i = 1'b0, irq_tmr_i = 1'b0;
    logic        mstatus_mie_i = 1'b0, mie_meie_i = 1'b0, mie_mtie_i = 1'b0;
    logic [31:0] mtvec_i = '0, mepc_i = '0;
    logic        csr_wait_o, csr_ret_o, trap_take_o, redirect_o, flush_o, halt_o;
    logic [31:0] trap_cause_o, trap_epc_o, redirect_pc_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    csr_trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .wfi_i(wfi_i), .mret_i(mret_i),
        .stall_i(stall_i), .irq_ext_i(irq_ext_i), .irq_tmr_i(irq_tmr_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_meie_i(mie_meie_i), .mie_mtie_i(mie_mtie_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_wait_o(csr_wait_o), .csr_ret_o(csr_ret_o), .trap_take_o(trap_take_o),
        .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .halt_o(halt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 trap, 1 mret, 2 wake
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] pc;
        int          due;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Reference model: an event decided at one edge is presented after the following edge.
    bit          asleep = 1'b0;
    bit          fin_valid = 1'b0;
    int          fin_kind = 0;
    logic [31:0] fin_cause = '0, fin_epc = '0, wake_pc = '0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            asleep = 1'b0;
            fin_valid = 1'b0;
            q.delete();
        end else begin
            bit pe, pt, tk;
            cyc++;
            pe = irq_ext_i && mie_meie_i;
            pt = irq_tmr_i && mie_mtie_i;
            tk = mstatus_mie_i && (pe || pt);
            if (fin_valid) begin
                exp_t e;
                e.kind  = fin_kind;
                e.cause = fin_cause;
                e.epc   = fin_epc;
                e.pc    = (fin_kind == 0) ? (mtvec_i & 32'hFFFF_FFFC) :
                          (fin_kind == 1) ? mepc_i : wake_pc;
                e.due   = cyc;
                q.push_back(e);
                fin_valid = 1'b0;
            end else if (asleep) begin
                if (pe || pt) begin
                    asleep = 1'b0;
                    fin_valid = 1'b1;
                    fin_kind = tk ? 0 : 2;
                    fin_cause = pe ? 32'h8000_000B : 32'h8000_0007;
                    fin_epc = wake_pc;
                end
            end else if (ex_valid_i && !stall_i) begin
                if (tk) begin
                    fin_valid = 1'b1;
                    fin_kind = 0;
                    fin_cause = pe ? 32'h8000_000B : 32'h8000_0007;
                    fin_epc = ex_pc_i;
                end else if (mret_i) begin
                    fin_valid = 1'b1;
                    fin_kind = 1;
                end else if (wfi_i) begin
                    asleep = 1'b1;
                    wake_pc = ex_pc_i + 32'd4;
                end
            end
        end
    end

    // Monitor: pops one expected event per DUT pulse, also tracks the sleep levels.
    initial forever begin
        @(negedge clk);
        if (q.size() > 0 && q[0].due < cyc) begin
            exp_t m;
            m = q.pop_front();
            chk("missed_event_due", 32'(cyc), 32'(m.due));
        end
        if (trap_take_o || csr_ret_o || redirect_o || flush_o) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {28'd0, trap_take_o, csr_ret_o, redirect_o, flush_o}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_cycle", 32'(cyc), 32'(e.due));
                chk("trap_take", 32'(trap_take_o), 32'(e.kind == 0));
                chk("csr_ret", 32'(csr_ret_o), 32'(e.kind == 1));
                chk("redirect", 32'(redirect_o), 32'd1);
                chk("flush", 32'(flush_o), 32'd1);
                chk("redirect_pc", redirect_pc_o, e.pc);
                if (e.kind == 0) begin
                    chk("trap_cause", trap_cause_o, e.cause);
                    chk("trap_epc", trap_epc_o, e.epc);
                end
            end
        end
        chk("csr_wait", 32'(csr_wait_o), 32'(asleep));
        chk("halt", 32'(halt_o), 32'(asleep));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ex_valid_i = 1'b0; wfi_i = 1'b0; mret_i = 1'b0; stall_i = 1'b0;
        irq_ext_i = 1'b0; irq_tmr_i = 1'b0;
        mstatus_mie_i = 1'b0; mie_meie_i = 1'b0; mie_mtie_i = 1'b0;
    endtask

    task automatic sleep_at(input logic [31:0] pc, input logic mie);
        idle();
        mstatus_mie_i = mie; mie_meie_i = 1'b1;
        ex_valid_i = 1'b1; wfi_i = 1'b1; ex_pc_i = pc;
        tick();
        ex_valid_i = 1'b0; wfi_i = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_trap_take", 32'(trap_take_o), 32'd0);
        chk("rst_csr_ret", 32'(csr_ret_o), 32'd0);
        chk("rst_redirect", 32'(redirect_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_csr_wait", 32'(csr_wait_o), 32'd0);
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_cause", trap_cause_o, 32'd0);
        chk("rst_epc", trap_epc_o, 32'd0);
        chk("rst_redirect_pc", redirect_pc_o, 32'd0);
        rstn = 1'b1;
        tick();

        // Timer interrupt into mtvec 0x203
        mstatus_mie_i = 1'b1; mie_mtie_i = 1'b1; irq_tmr_i = 1'b1;
        ex_valid_i = 1'b1; ex_pc_i = 32'h100; mtvec_i = 32'h203;
        tick(); idle(); repeat (4) tick();

        // Both lines plus MRET: external interrupt wins
        mstatus_mie_i = 1'b1; mie_meie_i = 1'b1; mie_mtie_i = 1'b1;
        irq_ext_i = 1'b1; irq_tmr_i = 1'b1; mret_i = 1'b1; ex_valid_i = 1'b1; ex_pc_i = 32'h140;
        tick(); idle(); repeat (4) tick();

        // Plain MRET
        mepc_i = 32'h104; mret_i = 1'b1; ex_valid_i = 1'b1; ex_pc_i = 32'h180;
        tick(); idle(); repeat (4) tick();

        // WFI with MIE=0 then wake on external line
        sleep_at(32'h80, 1'b0);
        irq_ext_i = 1'b1; tick(); irq_ext_i = 1'b0; repeat (4) tick();

        // WFI with MIE=1 then trap with epc = wake pc
        sleep_at(32'h80, 1'b1);
        irq_ext_i = 1'b1; tick(); idle(); repeat (4) tick();

        // WFI with pending-enabled interrupt but MIE=0 acts as a NOP
        idle(); mie_meie_i = 1'b1; irq_ext_i = 1'b1;
        ex_valid_i = 1'b1; wfi_i = 1'b1; ex_pc_i = 32'h300;
        tick(); idle(); repeat (4) tick();

        // Stall hold for 5 cycles, trap on the first unstalled edge
        mstatus_mie_i = 1'b1; mie_mtie_i = 1'b1; irq_tmr_i = 1'b1;
        ex_valid_i = 1'b1; ex_pc_i = 32'h400; stall_i = 1'b1;
        repeat (5) tick();
        stall_i = 1'b0; tick(); idle(); repeat (4) tick();

        // PC + 4 wraps to zero
        sleep_at(32'hFFFF_FFFC, 1'b0);
        irq_ext_i = 1'b1; tick(); idle(); repeat (4) tick();

        // Asynchronous reset in the middle of SLEEP
        sleep_at(32'h500, 1'b0);
        rstn = 1'b0;
        #1;
        chk("rst_mid_sleep_wait", 32'(csr_wait_o), 32'd0);
        chk("rst_mid_sleep_halt", 32'(halt_o), 32'd0);
        tick(); rstn = 1'b1;
        repeat (4) tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ex_valid_i    = ($urandom_range(0, 3) != 0);
            ex_pc_i       = $urandom & 32'hFFFF_FFFC;
            wfi_i         = ($urandom_range(0, 5) == 0);
            mret_i        = ($urandom_range(0, 7) == 0);
            stall_i       = ($urandom_range(0, 4) == 0);
            irq_ext_i     = ($urandom_range(0, 6) == 0);
            irq_tmr_i     = ($urandom_range(0, 8) == 0);
            mstatus_mie_i = 1'($urandom);
            mie_meie_i    = 1'($urandom);
            mie_mtie_i    = 1'($urandom);
            mtvec_i       = $urandom;
            mepc_i        = $urandom;
            tick();
        end
        idle();
        repeat (6) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
